// File: rtl/int_rx_pkg.sv
// rtl/int_rx_pkg.sv - shared state type, default constants and saturating add for int_rx
package int_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_LIMIT = 2'd2,
        ST_COOL  = 2'd3
    } state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_FILT_LEN   = 4;
    localparam int DEF_MAX_ON     = 20000;
    localparam int DEF_MIN_OFF    = 500;
    localparam int DEF_DUTY_SHIFT = 3;

    // a + b clamped at lim; the 33-bit sum keeps the carry so wrap-around is impossible
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sat_add = (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - single-cycle rising-edge pulse from a synchronous level
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    // remember last cycle's level to spot the 0->1 transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/glitch_filt.sv
// rtl/glitch_filt.sv - synchroniser plus run-length filter producing the clean interrupter level
module glitch_filt #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_int_f
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic          w_s;
    logic [CW-1:0] r_cnt;
    logic          r_int_f;

    sync #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_raw),
        .o_q (w_s)
    );

    // count consecutive samples that disagree with the filtered level; flip on the FILT_LEN-th
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_int_f <= 1'b0;
        end else if (w_s == r_int_f) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_int_f <= w_s;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_int_f = r_int_f;

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - two-flop synchroniser for asynchronous inputs
module sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    // first flop absorbs metastability, second presents a clean level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/int_rx.sv
// rtl/int_rx.sv - interrupter receiver: filter, on/off timing, gen-synchronous bridge enable (option: DUTY_LIMIT_EN)
module int_rx
    import int_rx_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FILT_LEN   = DEF_FILT_LEN,
    parameter int MAX_ON     = DEF_MAX_ON,
    parameter int MIN_OFF    = DEF_MIN_OFF,
    parameter int DUTY_SHIFT = DEF_DUTY_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_raw,
    input  logic             gen,
    output logic             out,
    output logic [CNT_W-1:0] on_cnt,
    output logic             fault
);

    localparam logic [31:0]      CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] MAX_ON_C  = CNT_W'(MAX_ON);
    localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);

    generate
        if (CNT_W < 1 || CNT_W > 31) begin : g_chk_cnt_w
            $error("int_rx: CNT_W must be in 1..31");
        end
        if (MAX_ON < 1 || MAX_ON >= (1 << CNT_W)) begin : g_chk_max_on
            $error("int_rx: MAX_ON must be in 1..2^CNT_W-1");
        end
        if (MIN_OFF < 0 || MIN_OFF >= (1 << CNT_W)) begin : g_chk_min_off
            $error("int_rx: MIN_OFF must be below 2^CNT_W");
        end
        if (FILT_LEN < 1 || DUTY_SHIFT < 0) begin : g_chk_misc
            $error("int_rx: FILT_LEN must be >= 1 and DUTY_SHIFT >= 0");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic             w_int_f;
    logic             w_gen_s;
    logic             w_gen_p;
    logic             r_int_f_d;
    logic             w_int_rise;
    logic             w_cap_on;
    logic             w_hit_limit;
    logic [CNT_W-1:0] r_on_timer;
    logic [CNT_W-1:0] r_off_timer;
    logic [CNT_W-1:0] r_on_cnt;
    logic             r_fault;
    logic             r_ff;
    logic [CNT_W-1:0] w_on_inc;
    logic [CNT_W-1:0] w_off_inc;
    logic [CNT_W-1:0] w_off_req;

    glitch_filt #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (int_raw),
        .o_int_f (w_int_f)
    );

    sync #(.W(1)) u_gen_sync (
        .clk (clk),
        .rst (rst),
        .i_d (gen),
        .o_q (w_gen_s)
    );

    edge_det u_gen_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (w_gen_s),
        .o_rise (w_gen_p)
    );

    assign w_int_rise = w_int_f & ~r_int_f_d;
    assign w_on_inc   = CNT_W'(sat_add(32'(r_on_timer), 32'd1, CNT_MAX));
    assign w_off_inc  = CNT_W'(sat_add(32'(r_off_timer), 32'd1, CNT_MAX));

`ifdef DUTY_LIMIT_EN
    localparam int SW = CNT_W + DUTY_SHIFT;

    logic [SW-1:0]    w_scaled;
    logic [CNT_W-1:0] w_scaled_sat;

    // off time scales with the last on time so average duty stays bounded
    assign w_scaled     = SW'(r_on_cnt) << DUTY_SHIFT;
    assign w_scaled_sat = (w_scaled > SW'(CNT_MAX)) ? CNT_W'(CNT_MAX) : w_scaled[CNT_W-1:0];
    assign w_off_req    = (w_scaled_sat > MIN_OFF_C) ? w_scaled_sat : MIN_OFF_C;
`else
    assign w_off_req = MIN_OFF_C;
`endif

    // state register; reset lands in COOL so a pulse in flight at reset is never resumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COOL;
        end else begin
            r_state <= w_next;
        end
    end

    // next state plus capture/limit strobes; a falling int_f beats a simultaneous limit hit
    always_comb begin
        w_next      = r_state;
        w_cap_on    = 1'b0;
        w_hit_limit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_int_rise) begin
                    w_next = ST_ON;
                end
            end
            ST_ON: begin
                if (!w_int_f) begin
                    w_next   = ST_COOL;
                    w_cap_on = 1'b1;
                end else if (r_on_timer == MAX_ON_C) begin
                    w_next      = ST_LIMIT;
                    w_hit_limit = 1'b1;
                end
            end
            ST_LIMIT: begin
                if (!w_int_f) begin
                    w_next = ST_COOL;
                end
            end
            ST_COOL: begin
                if (!w_int_f && (r_off_timer >= w_off_req)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_COOL;
        endcase
    end

    // on/off timers, recorded on-time and sticky fault
    always_ff @(posedge clk) begin
        if (rst) begin
            r_on_timer  <= '0;
            r_off_timer <= '0;
            r_on_cnt    <= '0;
            r_fault     <= 1'b0;
            r_int_f_d   <= 1'b0;
        end else begin
            r_int_f_d <= w_int_f;
            if (r_state == ST_IDLE) begin
                r_on_timer <= CNT_W'(1);
            end else if (r_state == ST_ON) begin
                r_on_timer <= w_on_inc;
            end
            if ((w_next == ST_COOL) && (r_state != ST_COOL)) begin
                r_off_timer <= '0;
            end else if (r_state == ST_COOL) begin
                r_off_timer <= w_off_inc;
            end
            if (w_cap_on) begin
                r_on_cnt <= r_on_timer;
            end
            if (w_hit_limit) begin
                r_on_cnt <= MAX_ON_C;
                r_fault  <= 1'b1;
            end
        end
    end

    // bridge enable only changes on gen rising edges, except a limit cut which is immediate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff <= 1'b0;
        end else if (w_hit_limit || (r_state == ST_LIMIT)) begin
            r_ff <= 1'b0;
        end else if (w_gen_p) begin
            r_ff <= (r_state == ST_ON);
        end
    end

    assign out    = r_ff & w_gen_s;
    assign on_cnt = r_on_cnt;
    assign fault  = r_fault;

endmodule
